// File: rtl/fx_ctrl_fsm.sv
// fx_ctrl_fsm: pedal front-panel control core with parameter editing and a loop record/playback sequencer
module fx_ctrl_fsm #(
  parameter int N_FX = 8,
  parameter int PARAM_W = 3,
  parameter int MAX_VAL = 7,
  parameter int SATURATE = 1,
  parameter logic [N_FX*PARAM_W-1:0] INIT_VAL = '0,
  parameter int DEPTH = 1048576,
  localparam int SEL_W = N_FX > 1 ? $clog2(N_FX) : 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_init_done,
  input  logic                     i_key_up,
  input  logic                     i_key_dn,
  input  logic                     i_key_loop,
  input  logic                     i_key_mode,
  input  logic [SEL_W-1:0]         i_fx_sel,
  input  logic                     i_sample_tick,
  output logic [2:0]               o_state,
  output logic [N_FX*PARAM_W-1:0]  o_params,
  output logic [PARAM_W-1:0]       o_cur_val,
  output logic [N_FX-1:0]          o_sel_onehot,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic                     o_mem_we,
  output logic                     o_mem_re,
  output logic [ADDR_W:0]          o_loop_len
);
  typedef enum logic [2:0] {INIT = 3'd0, PLAY = 3'd1, SET = 3'd2, REC = 3'd3, LOOP = 3'd4} state_t;
  localparam logic [PARAM_W-1:0] MAX_P = PARAM_W'(MAX_VAL);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_t state, state_n;
  logic [PARAM_W-1:0] cur, nv;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W:0] len_n, len_w;
  logic step;
  assign o_state = state;
  assign o_cur_val = cur;
  assign step = i_key_up ^ i_key_dn;
  always_comb begin
    cur = '0;
    o_sel_onehot = '0;
    for (int k = 0; k < N_FX; k++) begin
      o_sel_onehot[k] = state == SET && i_fx_sel == SEL_W'(k);
      if (o_sel_onehot[k]) cur = o_params[k*PARAM_W +: PARAM_W];
    end
  end
  assign nv = i_key_up ? (cur == MAX_P ? (SATURATE != 0 ? MAX_P : '0) : cur + 1'b1)
                       : (cur == '0 ? (SATURATE != 0 ? '0 : MAX_P) : cur - 1'b1);
  always_ff @(posedge i_clk)
    if (i_rst) o_params <= INIT_VAL;
    else if (step)
      for (int k = 0; k < N_FX; k++)
        if (o_sel_onehot[k]) o_params[k*PARAM_W +: PARAM_W] <= nv;
  always_comb begin
    state_n = state;
    addr_n = o_mem_addr;
    len_n = o_loop_len;
    o_mem_we = 1'b0;
    o_mem_re = 1'b0;
    len_w = o_loop_len + (ADDR_W+1)'(i_sample_tick);
    case (state)
      INIT: state_n = i_init_done ? PLAY : INIT;
      PLAY: begin
        state_n = i_key_mode ? SET : i_key_loop ? REC : PLAY;
        if (!i_key_mode && i_key_loop) begin
          addr_n = '0;
          len_n = '0;
        end
      end
      SET: state_n = i_key_mode ? PLAY : SET;
      REC: begin
        o_mem_we = i_sample_tick;
        len_n = len_w;
        addr_n = o_mem_addr + ADDR_W'(i_sample_tick);
        // a same-cycle tick write is counted before the loop key decides LOOP vs PLAY
        if (len_w == DEPTH_L || (i_key_loop && len_w != '0)) begin
          state_n = LOOP;
          addr_n = '0;
        end else if (i_key_loop) state_n = PLAY;
      end
      LOOP: begin
        o_mem_re = i_sample_tick;
        if (i_key_loop) begin
          state_n = PLAY;
          addr_n = '0;
        end else if (i_sample_tick)
          addr_n = {1'b0, o_mem_addr} == o_loop_len - 1'b1 ? '0 : o_mem_addr + 1'b1;
      end
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= INIT;
      o_mem_addr <= '0;
      o_loop_len <= '0;
    end else begin
      state <= state_n;
      o_mem_addr <= addr_n;
      o_loop_len <= len_n;
    end
endmodule

// File: tb/tb_fx_ctrl_fsm.sv
// tb_fx_ctrl_fsm: directed checks of two fx_ctrl_fsm configurations sharing one stimulus stream
module tb_fx_ctrl_fsm;
  localparam logic [17:0] INIT_B = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, init_done, up, dn, lp, md, tick;
  logic [2:0] sel;
  logic [2:0] st_a, cur_a, st_b, cur_b;
  logic [23:0] par_a;
  logic [17:0] par_b;
  logic [7:0] oh_a;
  logic [5:0] oh_b;
  logic [19:0] addr_a, c_addr_a;
  logic [20:0] len_a;
  logic [1:0] addr_b, c_addr_b;
  logic [2:0] len_b;
  logic we_a, re_a, we_b, re_b, c_we_a, c_re_a, c_we_b, c_re_b;
  int checks = 0, errors = 0;

  fx_ctrl_fsm #(.N_FX(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_init_done(init_done), .i_key_up(up), .i_key_dn(dn),
    .i_key_loop(lp), .i_key_mode(md), .i_fx_sel(sel), .i_sample_tick(tick),
    .o_state(st_a), .o_params(par_a), .o_cur_val(cur_a), .o_sel_onehot(oh_a),
    .o_mem_addr(addr_a), .o_mem_we(we_a), .o_mem_re(re_a), .o_loop_len(len_a));

  fx_ctrl_fsm #(.N_FX(6), .SATURATE(0), .INIT_VAL(INIT_B), .DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_init_done(init_done), .i_key_up(up), .i_key_dn(dn),
    .i_key_loop(lp), .i_key_mode(md), .i_fx_sel(sel), .i_sample_tick(tick),
    .o_state(st_b), .o_params(par_b), .o_cur_val(cur_b), .o_sel_onehot(oh_b),
    .o_mem_addr(addr_b), .o_mem_we(we_b), .o_mem_re(re_b), .o_loop_len(len_b));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic cyc(input logic u, input logic d, input logic l, input logic m, input logic t);
    up = u; dn = d; lp = l; md = m; tick = t;
    #1;
    c_we_a = we_a; c_re_a = re_a; c_addr_a = addr_a;
    c_we_b = we_b; c_re_b = re_b; c_addr_b = addr_b;
    @(posedge clk);
    #1;
    up = 0; dn = 0; lp = 0; md = 0; tick = 0;
  endtask

  typedef struct {
    logic u, d, l, m;
    logic [2:0] sel;
    int rep;
    logic [2:0] st, ea, eb;
  } vec_t;
  vec_t v[11];

  initial begin
    v[0]  = '{1, 0, 0, 0, 3, 7, 2, 7, 2};
    v[1]  = '{1, 0, 0, 0, 3, 2, 2, 7, 4};
    v[2]  = '{0, 1, 0, 0, 3, 9, 2, 0, 3};
    v[3]  = '{0, 1, 0, 0, 3, 3, 2, 0, 0};
    v[4]  = '{0, 1, 0, 0, 3, 1, 2, 0, 7};
    v[5]  = '{1, 0, 0, 0, 3, 1, 2, 1, 0};
    v[6]  = '{1, 1, 0, 0, 3, 1, 2, 1, 0};
    v[7]  = '{1, 0, 0, 0, 6, 1, 2, 1, 0};
    v[8]  = '{0, 0, 1, 0, 3, 1, 2, 1, 0};
    v[9]  = '{1, 0, 0, 1, 3, 1, 1, 2, 1};
    v[10] = '{1, 0, 0, 0, 3, 1, 1, 2, 1};
    rst = 1; init_done = 0; up = 0; dn = 0; lp = 0; md = 0; tick = 0; sel = 3'd3;
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_state", 32'(st_a), 0);
    chk("rst_params_a", 32'(par_a), 0);
    chk("rst_params_b", 32'(par_b), 32'(INIT_B));
    chk("rst_addr_len", 32'({addr_a, len_a}), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 1, 1);
      chk($sformatf("init_hold%0d", i), 32'(st_a), 0);
      chk($sformatf("init_strobes%0d", i), 32'({c_we_a, c_re_a, c_we_b, c_re_b}), 0);
    end
    init_done = 1;
    cyc(0, 0, 0, 0, 0);
    chk("init_to_play", 32'({st_a, st_b}), 32'({3'd1, 3'd1}));
    cyc(0, 0, 0, 1, 0);
    chk("play_to_set", 32'(st_a), 2);
    foreach (v[i]) begin
      sel = v[i].sel;
      for (int r = 0; r < v[i].rep; r++) cyc(v[i].u, v[i].d, v[i].l, v[i].m, 0);
      chk($sformatf("vec%0d_state", i), 32'({st_a, st_b}), 32'({v[i].st, v[i].st}));
      chk($sformatf("vec%0d_param_a", i), 32'(par_a[v[i].sel*3 +: 3]), 32'(v[i].ea));
      if (v[i].sel < 6) chk($sformatf("vec%0d_param_b", i), 32'(par_b[v[i].sel*3 +: 3]), 32'(v[i].eb));
    end
    chk("params_a_all", 32'(par_a), 32'h40400);
    chk("params_b_all", 32'(par_b), 32'({3'd5, 3'd4, 3'd1, 3'd2, 3'd1, 3'd6}));
    chk("play_cur_oh", 32'({cur_a, oh_a}), 0);
    cyc(0, 0, 0, 1, 0);
    sel = 3'd3;
    #1;
    chk("set_sel3_a", 32'({cur_a, oh_a}), 32'({3'd2, 8'h08}));
    chk("set_sel3_b", 32'({cur_b, oh_b}), 32'({3'd1, 6'h08}));
    sel = 3'd6;
    #1;
    chk("set_sel6_a", 32'({cur_a, oh_a}), 32'({3'd1, 8'h40}));
    chk("set_sel6_b", 32'({cur_b, oh_b}), 0);
    cyc(0, 0, 0, 1, 0);
    sel = 3'd3;
    cyc(0, 0, 1, 0, 0);
    chk("rec_entry", 32'({st_a, st_b, len_a, addr_a}), 32'({3'd3, 3'd3, 41'd0}));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cyc(1, 0, 0, 1, 0);
        chk("rec_ignores_mode_up", 32'({st_a, st_b}), 32'({3'd3, 3'd3}));
        chk("rec_params_held", 32'(par_a), 32'h40400);
      end
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("rec_we_a%0d", i), 32'({c_we_a, c_addr_a}), 32'({1'b1, 20'(i)}));
      if (i < 4) chk($sformatf("rec_we_b%0d", i), 32'({c_we_b, c_addr_b}), 32'({1'b1, 2'(i)}));
      else chk("b_no_fifth_write", 32'({c_we_b, c_re_b, c_addr_b}), 32'({1'b0, 1'b1, 2'd0}));
      if (i == 3) chk("b_auto_loop", 32'({st_b, len_b, addr_b}), 32'({3'd4, 3'd4, 2'd0}));
    end
    chk("rec_len_a", 32'({st_a, len_a}), 32'({3'd3, 21'd5}));
    cyc(0, 0, 1, 0, 0);
    chk("loop_entry_a", 32'({st_a, len_a, addr_a}), 32'({3'd4, 21'd5, 20'd0}));
    chk("loop_exit_b", 32'({st_b, len_b, addr_b}), 32'({3'd1, 3'd4, 2'd0}));
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("play_re%0d", i), 32'({c_we_a, c_re_a, c_addr_a}), 32'({1'b0, 1'b1, 20'(i % 5)}));
    end
    chk("loop_addr2", 32'({st_a, addr_a}), 32'({3'd4, 20'd2}));
    chk("loop_params_held", 32'(par_a), 32'h40400);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midloop_rst", 32'({st_a, addr_a, len_a}), 0);
    chk("midloop_rst_pa", 32'(par_a), 0);
    chk("midloop_rst_pb", 32'(par_b), 32'(INIT_B));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("empty_rec_to_play", 32'({st_a, st_b, len_a}), 32'({3'd1, 3'd1, 21'd0}));
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("tick_loop_write", 32'({c_we_a, c_addr_a}), 32'({1'b1, 20'd2}));
    chk("tick_loop_a", 32'({st_a, len_a, addr_a}), 32'({3'd4, 21'd3, 20'd0}));
    chk("tick_loop_b", 32'({st_b, len_b, addr_b}), 32'({3'd4, 3'd3, 2'd0}));
    cyc(0, 0, 1, 0, 1);
    chk("stop_read", 32'({c_re_a, c_addr_a}), 32'({1'b1, 20'd0}));
    chk("stop_to_play", 32'({st_a, len_a, addr_a}), 32'({3'd1, 21'd3, 20'd0}));
    cyc(0, 0, 1, 1, 0);
    chk("mode_beats_loop", 32'({st_a, st_b}), 32'({3'd2, 3'd2}));
    cyc(0, 0, 0, 1, 0);
    chk("set_to_play", 32'(st_a), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_ctrl_fsm.md
Name: fx_ctrl_fsm

Overview:
- Parametrised control core for the pedal front panel.
- Replaces the fixed 8-effect, 3-bit parameter control logic with configurable effect count, parameter width and range, plus a saturate/wrap mode.
- Adds an up/down value keypair and a working loop record/playback sequencer that drives loop-memory address and strobes.
- Sits between debounced keys/switches and the effect chain, LED drivers and the SRAM loop-memory interface.

Parameters:
N_FX, 8, number of effects with a settable parameter (1..16)
PARAM_W, 3, parameter register width in bits
MAX_VAL, 7, largest legal parameter value (must be at most 2^PARAM_W-1)
SATURATE, 1, 1 = clamp at 0/MAX_VAL; 0 = wrap modulo MAX_VAL+1
INIT_VAL, {N_FX{3'd0}}, flat N_FX*PARAM_W reset values; effect k occupies bits [k*PARAM_W +: PARAM_W]
DEPTH, 1048576, loop memory depth in samples (at least 2)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_init_done  in  1  codec I2C initialisation finished (level)
i_key_up  in  1  one-cycle pulse: increment selected parameter
i_key_dn  in  1  one-cycle pulse: decrement selected parameter
i_key_loop  in  1  one-cycle pulse: loop record/play/stop
i_key_mode  in  1  one-cycle pulse: toggle PLAY/SET
i_fx_sel  in  SEL_W=max(1,$clog2(N_FX))  selected effect index
i_sample_tick  in  1  one-cycle pulse per audio sample (DACLRCK rising edge)
o_state  out  3  INIT=0 PLAY=1 SET=2 REC=3 LOOP=4
o_params  out  N_FX*PARAM_W  all parameter registers, flat
o_cur_val  out  PARAM_W  parameter of i_fx_sel while in SET, else 0
o_sel_onehot  out  N_FX  one-hot of i_fx_sel while in SET, else 0
o_mem_addr  out  ADDR_W=$clog2(DEPTH)  loop memory address
o_mem_we  out  1  write strobe (REC)
o_mem_re  out  1  read strobe (LOOP)
o_loop_len  out  ADDR_W+1  recorded loop length in samples

Behaviour:
- Reset (i_rst=1 at the clock edge) takes priority over every other input, including mid-record and mid-playback.
- Reset values: o_state=INIT, params=INIT_VAL, o_mem_addr=0, o_loop_len=0, o_mem_we=o_mem_re=0.
- o_state, params, o_mem_addr and o_loop_len are registered. o_mem_we, o_mem_re, o_cur_val and o_sel_onehot are combinational from registered state and the current inputs.
- INIT:
  - i_init_done=1 -> PLAY. All keys are ignored.
- PLAY:
  - i_key_mode -> SET.
  - Else i_key_loop -> REC, with o_mem_addr<=0 and o_loop_len<=0.
  - i_key_mode has priority when both keys pulse in the same cycle.
- SET:
  - i_key_mode -> PLAY.
  - i_key_up / i_key_dn modify param[i_fx_sel] one step per pulse.
  - i_key_up and i_key_dn together: no change.
  - i_fx_sel >= N_FX: no change, o_cur_val=0, o_sel_onehot=0.
  - SATURATE=1: up at MAX_VAL stays at MAX_VAL; dn at 0 stays at 0.
  - SATURATE=0: up at MAX_VAL -> 0; dn at 0 -> MAX_VAL.
  - A mode pulse in the same cycle as up/dn applies the value change and the transition together.
  - i_key_loop is ignored.
- REC:
  - On i_sample_tick: o_mem_we=1 in that cycle with the current o_mem_addr. Next edge: o_mem_addr+1, o_loop_len+1.
  - When the write at addr DEPTH-1 completes (o_loop_len becomes DEPTH): auto -> LOOP, o_mem_addr<=0.
  - i_key_loop: any same-cycle tick write counts first. Then -> LOOP with o_mem_addr<=0 if the resulting length > 0, else -> PLAY.
  - i_key_mode and up/dn are ignored.
- LOOP:
  - On i_sample_tick: o_mem_re=1 with the current o_mem_addr.
  - Next edge: o_mem_addr <= (o_mem_addr == o_loop_len-1) ? 0 : o_mem_addr+1.
  - i_key_loop -> PLAY, o_mem_addr<=0. o_loop_len is retained (read-only status) until the next REC entry.
  - A same-cycle tick still issues its read.
- o_mem_we is 0 outside REC; o_mem_re is 0 outside LOOP.
- Parameters are held in all states except SET.
- Undefined state encodings (5..7) -> INIT on the next edge.

Test Plan:
- Reset, hold i_init_done=0 for 10 cycles, then raise it -> o_state 0 throughout, then 1 one cycle after; o_params==INIT_VAL; all strobes 0.
- SATURATE=1, MAX_VAL=7: SET, sel=3, 9 up pulses -> param[3]=7; 9 dn pulses -> 0. Repeat with SATURATE=0 -> up from 7 gives 0, dn from 0 gives 7. sel=N_FX (with N_FX=6) -> no register changes.
- PLAY, loop pulse, 5 ticks, loop pulse -> o_mem_we at addr 0..4, o_loop_len=5, LOOP. Then 12 ticks -> o_mem_re addresses 0,1,2,3,4,0,1,...,1.
- DEPTH=4: REC, 4 ticks -> auto LOOP after the 4th write, o_loop_len=4, o_mem_addr=0, no fifth write.
- REC entered, immediate loop pulse with no tick -> PLAY, o_loop_len=0. Tick and loop pulse in the same cycle after 2 ticks -> o_loop_len=3.
- i_rst pulsed during LOOP at addr 2 -> next cycle INIT, addr 0, len 0, params=INIT_VAL.
